// File: rtl/mem_arb_pkg.sv
// Shared widths, owner-state encoding and address range helper for the
// fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Which port owns the response slot in the cycle after a grant
  typedef enum logic [2:0] {
    NONE,
    IF_RD,
    D_RD,
    IF_ERR,
    D_ERR
  } owner_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [31:0]       words);
    return {2'b00, addr} < words;
  endfunction

endpackage

// File: rtl/mem_arb_age_counter.sv
// Fetch-port age counter: counts consecutive denied fetch cycles and raises
// a starvation flag once the count reaches MAX_WAIT.
module mem_arb_age_counter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;

  always_comb begin
    wait_d = wait_q;
    if (gnt) begin
      wait_d = '0;
    end else if (req && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Flag is registered alongside the count so it tracks wait_q == MAX_WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q  <= '0;
      starved <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      starved <= (wait_d == WAIT_MAX);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory with data-port
// priority, fetch anti-starvation and out-of-range error responses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32768,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_read_ready,
  output logic              mem_write_ready,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [STRB_W-1:0] mem_write_byte,
  input  logic [DATA_W-1:0] mem_read_data
);

  owner_e owner_q;
  owner_e owner_d;
  logic   starved;
  logic   if_ok;
  logic   d_ok;

  assign if_ok = addr_in_range(if_addr, 32'(MEM_WORDS));
  assign d_ok  = addr_in_range(d_addr, 32'(MEM_WORDS));

  mem_arb_age_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk     (clk),
    .reset   (reset),
    .req     (if_req),
    .gnt     (if_gnt),
    .starved (starved)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Grant is combinational and suppressed during reset so nothing reaches memory
  always_comb begin
    if_gnt            = 1'b0;
    d_gnt             = 1'b0;
    mem_read_ready    = 1'b0;
    mem_write_ready   = 1'b0;
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_write_byte    = '0;
    owner_d           = NONE;
    if (!reset) begin
      if (if_req && (starved || !d_req)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
    if (if_gnt) begin
      if (if_ok) begin
        mem_read_ready   = 1'b1;
        mem_read_address = if_addr;
        owner_d          = IF_RD;
      end else begin
        owner_d = IF_ERR;
      end
    end else if (d_gnt) begin
      if (!d_ok) begin
        owner_d = D_ERR;
      end else if (d_we) begin
        mem_write_ready   = 1'b1;
        mem_write_address = d_addr;
        mem_write_data    = d_wdata;
        mem_write_byte    = d_wstrb;
      end else begin
        mem_read_ready   = 1'b1;
        mem_read_address = d_addr;
        owner_d          = D_RD;
      end
    end
  end

  always_comb begin
    if_rvalid = (owner_q == IF_RD) || (owner_q == IF_ERR);
    if_err    = (owner_q == IF_ERR);
    if_rdata  = (owner_q == IF_RD) ? mem_read_data : '0;
    d_rvalid  = (owner_q == D_RD) || (owner_q == D_ERR);
    d_err     = (owner_q == D_ERR);
    d_rdata   = (owner_q == D_RD) ? mem_read_data : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-writable memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_read_ready, mem_write_ready;
  logic [29:0] mem_read_address, mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_byte;
  logic [31:0] mem_read_data;

  logic [31:0] mem [64];
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_WORDS (64),
    .MAX_WAIT  (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_gnt            (if_gnt),
    .if_rvalid         (if_rvalid),
    .if_rdata          (if_rdata),
    .if_err            (if_err),
    .d_req             (d_req),
    .d_we              (d_we),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_wstrb           (d_wstrb),
    .d_gnt             (d_gnt),
    .d_rvalid          (d_rvalid),
    .d_rdata           (d_rdata),
    .d_err             (d_err),
    .mem_read_ready    (mem_read_ready),
    .mem_write_ready   (mem_write_ready),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_byte    (mem_write_byte),
    .mem_read_data     (mem_read_data)
  );

  // Memory word i starts as 0xC0DE0000 | i; read data appears one cycle later
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem_read_data <= '0;
    end else begin
      if (mem_read_ready) mem_read_data <= mem[mem_read_address[5:0]];
      if (mem_write_ready)
        for (int b = 0; b < 4; b++)
          if (mem_write_byte[b])
            mem[mem_write_address[5:0]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b1; if_addr = 30'd5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h10; d_wdata = '0; d_wstrb = '0;

    // Reset: everything quiet despite pending requests
    @(negedge clk); #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_rd", 32'(mem_read_ready), 32'd0);
    chk("rst_mem_wr", 32'(mem_write_ready), 32'd0);
    chk("rst_mem_raddr", 32'(mem_read_address), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);

    // First cycle after release: data wins the simultaneous request
    @(negedge clk); reset = 1'b0; #1;
    chk("prio_d_gnt", 32'(d_gnt), 32'd1);
    chk("prio_if_gnt", 32'(if_gnt), 32'd0);
    chk("prio_mem_rd", 32'(mem_read_ready), 32'd1);
    chk("prio_mem_raddr", 32'(mem_read_address), 32'h10);

    @(negedge clk); d_req = 1'b0; #1;
    chk("fetch_gnt", 32'(if_gnt), 32'd1);
    chk("prio_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("prio_d_rdata", d_rdata, 32'hC0DE_0010);

    // Starvation: six contended cycles, fetch forced through in the fifth
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 30'd7; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h11;
      #1;
      chk("starve_if_gnt", 32'(if_gnt), (k == 5) ? 32'd1 : 32'd0);
      chk("starve_d_gnt", 32'(d_gnt), (k == 5) ? 32'd0 : 32'd1);
      if (k == 1) begin
        chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
        chk("fetch_rdata", if_rdata, 32'hC0DE_0005);
      end
      if (k == 6) begin
        chk("starve_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("starve_if_rdata", if_rdata, 32'hC0DE_0007);
        chk("starve_d_rvalid", 32'(d_rvalid), 32'd0);
      end
    end

    // Partial-strobe write, then read back
    @(negedge clk);
    if_req = 1'b0; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    #1;
    chk("wr_d_gnt", 32'(d_gnt), 32'd1);
    chk("wr_mem_wr", 32'(mem_write_ready), 32'd1);
    chk("wr_mem_rd", 32'(mem_read_ready), 32'd0);
    chk("wr_addr", 32'(mem_write_address), 32'h20);
    chk("wr_data", mem_write_data, 32'hDEAD_BEEF);
    chk("wr_strb", 32'(mem_write_byte), 32'h3);
    chk("starve6_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("starve6_d_rdata", d_rdata, 32'hC0DE_0011);

    @(negedge clk); d_we = 1'b0; #1;
    chk("wr_no_rvalid", 32'(d_rvalid), 32'd0);
    chk("wr_no_rdata", d_rdata, 32'd0);
    chk("rdback_mem_rd", 32'(mem_read_ready), 32'd1);
    chk("rdback_raddr", 32'(mem_read_address), 32'h20);

    // Idle with write qualifiers toggling: nothing must be forwarded
    @(negedge clk); d_req = 1'b0; d_we = 1'b1; d_wstrb = 4'hF; d_wdata = 32'h1234_5678; #1;
    chk("rdback_rvalid", 32'(d_rvalid), 32'd1);
    chk("rdback_rdata", d_rdata, 32'hC0DE_BEEF);
    chk("idle_mem_wr", 32'(mem_write_ready), 32'd0);
    chk("idle_mem_rd", 32'(mem_read_ready), 32'd0);
    chk("idle_d_gnt", 32'(d_gnt), 32'd0);

    // Out-of-range fetch at exactly MEM_WORDS
    @(negedge clk); d_we = 1'b0; if_req = 1'b1; if_addr = 30'd64; #1;
    chk("oor_if_gnt", 32'(if_gnt), 32'd1);
    chk("oor_if_mem_rd", 32'(mem_read_ready), 32'd0);

    @(negedge clk);
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 30'd100; d_wdata = 32'd1; d_wstrb = 4'hF;
    #1;
    chk("oor_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("oor_if_err", 32'(if_err), 32'd1);
    chk("oor_if_rdata", if_rdata, 32'd0);
    chk("oor_d_gnt", 32'(d_gnt), 32'd1);
    chk("oor_d_mem_wr", 32'(mem_write_ready), 32'd0);

    @(negedge clk); d_req = 1'b0; d_we = 1'b0; #1;
    chk("oor_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("oor_d_err", 32'(d_err), 32'd1);
    chk("oor_d_rdata", d_rdata, 32'd0);
    chk("oor_if_quiet", 32'(if_rvalid), 32'd0);
    chk("oor_if_err_clr", 32'(if_err), 32'd0);

    // Reset in the cycle after a fetch grant discards the response
    @(negedge clk); if_req = 1'b1; if_addr = 30'd3; #1;
    chk("pre_rst_if_gnt", 32'(if_gnt), 32'd1);

    @(negedge clk); reset = 1'b1; if_req = 1'b0; #1;
    chk("midrst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'd0);

    @(negedge clk); if_req = 1'b1; #1;
    chk("midrst_if_gnt", 32'(if_gnt), 32'd0);

    @(negedge clk); reset = 1'b0; if_addr = 30'd9; #1;
    chk("postrst_if_gnt", 32'(if_gnt), 32'd1);
    chk("postrst_no_stale", 32'(if_rvalid), 32'd0);

    // Alternating fetch/data reads, one response per grant one cycle later
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if_req = (i % 2 == 0); if_addr = 30'(i);
      d_req = (i % 2 == 1); d_we = 1'b0; d_addr = 30'(32'h28 + i);
      #1;
      chk("alt_if_gnt", 32'(if_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_d_gnt", 32'(d_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 0) begin
        chk("postrst_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("postrst_if_rdata", if_rdata, 32'hC0DE_0009);
      end else begin
        chk("alt_if_rvalid", 32'(if_rvalid), ((i - 1) % 2 == 0) ? 32'd1 : 32'd0);
        chk("alt_d_rvalid", 32'(d_rvalid), ((i - 1) % 2 == 1) ? 32'd1 : 32'd0);
        chk("alt_if_rdata", if_rdata,
            ((i - 1) % 2 == 0) ? (32'hC0DE_0000 | 32'(i - 1)) : 32'd0);
        chk("alt_d_rdata", d_rdata,
            ((i - 1) % 2 == 1) ? (32'hC0DE_0000 | 32'(32'h28 + i - 1)) : 32'd0);
      end
    end

    @(negedge clk); if_req = 1'b0; d_req = 1'b0; #1;
    chk("alt_last_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("alt_last_d_rdata", d_rdata, 32'hC0DE_003B);
    chk("alt_last_if_rvalid", 32'(if_rvalid), 32'd0);

    @(negedge clk); #1;
    chk("tail_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("tail_d_rvalid", 32'(d_rvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
